// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Scoreboard-based hazard unit for the pipelined RISC-V datapath.
//               Keeps a remaining-latency counter and an age per architectural
//               register. Multi-cycle producers (loads, multiplies) hold their
//               destination busy until the result is forwardable. A consumer in
//               ID stalls IF/ID while any source it reads is still busy.
//               A data-memory wait freezes the whole pipe. A branch or jump
//               redirect in MEM flushes IF/ID and ID/EX, and clears the
//               scoreboard entries of the squashed younger instructions.
//
// Parameters  : NREGS     - architectural register count (x0 never tracked)
//               LOAD_LAT  - cycles after issue until a load result forwards
//               MUL_LAT   - cycles after issue until a multiply result forwards
//               FLUSH_AGE - entries younger than this are squashed on redirect
//
// Ports       : CLK, RST            clock (rising edge), sync active-high reset
//               id_valid            ID holds a real instruction
//               id_rs1/id_rs2       ID source register indices
//               id_use_rs1/rs2      ID instruction reads rs1 / rs2
//               id_rd               ID destination register index
//               id_is_load/is_mul   ID instruction is a load / multiply
//               PCsrc, jal_mem,
//               jalr_mem            redirect sources resolved in MEM
//               mem_wait            data memory not ready, hold the pipe
//               flush               flush IF/ID and ID/EX
//               hazard_detected     RAW stall on the scoreboard
//               PC_write            PC enable
//               IFID_write          IF/ID latch enable
//               IDEX_bubble         insert NOP into ID/EX
//               IDEX_write          ID/EX latch enable
//               stall_cnt/flush_cnt performance counters (HAZARD_PERF_EN only)
//
// Options     : HAZARD_PERF_EN - when defined, adds free-running 32-bit
//               counters of stall cycles and flush cycles.
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREGS     = 32,
    parameter int LOAD_LAT  = 1,
    parameter int MUL_LAT   = 3,
    parameter int FLUSH_AGE = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_is_load,
    input  logic        id_is_mul,
    input  logic        PCsrc,
    input  logic        jal_mem,
    input  logic        jalr_mem,
    input  logic        mem_wait,
    output logic        flush,
    output logic        hazard_detected,
    output logic        PC_write,
    output logic        IFID_write,
    output logic        IDEX_bubble,
    output logic        IDEX_write
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
    localparam int c_AGE_W   = (FLUSH_AGE > 0) ? $clog2(FLUSH_AGE + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_LOAD_LAT = c_CNT_W'(LOAD_LAT);
    localparam logic [c_CNT_W-1:0] c_MUL_LAT  = c_CNT_W'(MUL_LAT);
    localparam logic [c_AGE_W-1:0] c_AGE_MAX  = c_AGE_W'(FLUSH_AGE);

    // ------------------------------------------------------------------------
    // Combinational hazard decision
    // ------------------------------------------------------------------------
    // One busy bit per 5-bit register index; index 0 and any index beyond
    // NREGS read as never busy, so x0 never stalls.
    logic [31:0]        w_busy;
    logic               w_redirect;
    logic               w_rs1_hit;
    logic               w_rs2_hit;
    logic               w_raw;
    logic               w_issue;
    logic               w_tracked;
    logic               w_rd_nz;
    logic [c_CNT_W-1:0] w_new_lat;

    assign w_redirect = PCsrc | jal_mem | jalr_mem;
    assign w_rs1_hit  = id_use_rs1 & (id_rs1 != 5'd0) & w_busy[id_rs1];
    assign w_rs2_hit  = id_use_rs2 & (id_rs2 != 5'd0) & w_busy[id_rs2];
    // rs1==rs2 collapses naturally: the OR sees the same busy bit twice.
    assign w_raw      = id_valid & (w_rs1_hit | w_rs2_hit);

    always_comb begin
        flush           = 1'b0;
        hazard_detected = 1'b0;
        PC_write        = 1'b1;
        IFID_write      = 1'b1;
        IDEX_bubble     = 1'b0;
        IDEX_write      = 1'b1;
        if (mem_wait) begin
            // Everything holds; a pending redirect stays in MEM and is
            // acted on once the memory is ready.
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
        end else if (w_redirect) begin
            flush       = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (w_raw) begin
            hazard_detected = 1'b1;
            PC_write        = 1'b0;
            IFID_write      = 1'b0;
            IDEX_bubble     = 1'b1;
        end
    end

    // An instruction leaves ID only when nothing above holds or kills it.
    assign w_issue   = id_valid & ~mem_wait & ~w_redirect & ~w_raw;
    assign w_tracked = id_is_load | id_is_mul;
    assign w_rd_nz   = (id_rd != 5'd0);
    // Load latency takes precedence if both type flags are set.
    assign w_new_lat = id_is_load ? c_LOAD_LAT : c_MUL_LAT;

    // ------------------------------------------------------------------------
    // Per-register scoreboard entries
    // ------------------------------------------------------------------------
    assign w_busy[0] = 1'b0;

    generate
        if (NREGS < 32) begin : g_pad
            assign w_busy[31:NREGS] = '0;
        end
    endgenerate

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [c_CNT_W-1:0] r_rem;
            logic [c_AGE_W-1:0] r_age;
            logic               w_rd_hit;

            assign w_rd_hit  = w_issue & w_rd_nz & (id_rd == 5'(gi));
            assign w_busy[gi] = (r_rem != '0);

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_rem <= '0;
                    r_age <= c_AGE_MAX;
                end else if (!mem_wait) begin
                    if (w_rd_hit && w_tracked) begin
                        // A fresh multi-cycle producer overrides everything.
                        r_rem <= w_new_lat;
                        r_age <= '0;
                    end else begin
                        r_age <= (r_age < c_AGE_MAX) ? r_age + 1'b1 : r_age;
                        if (w_rd_hit) begin
                            // Younger single-cycle writer: its result is
                            // forwarded normally, so the older pending one
                            // no longer matters.
                            r_rem <= '0;
                        end else if (w_redirect && (r_age < c_AGE_MAX)) begin
                            // Producer is among the flushed younger
                            // instructions; judged on its age before update.
                            r_rem <= '0;
                        end else if (r_rem != '0) begin
                            r_rem <= r_rem - 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (hazard_detected) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. The reference
//               model tracks, per register, the cycle (counted in non-waiting
//               cycles) at which its pending result becomes forwardable,
//               and derives the expected control outputs from that.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NREGS     = 32;
    localparam int LOAD_LAT  = 1;
    localparam int MUL_LAT   = 3;
    localparam int FLUSH_AGE = 1;

    // Output vector order: {flush, hazard, PC_write, IFID_write, bubble, IDEX_write}
    localparam logic [5:0] c_RUN   = 6'b001101;
    localparam logic [5:0] c_STALL = 6'b010011;
    localparam logic [5:0] c_REDIR = 6'b101111;
    localparam logic [5:0] c_WAIT  = 6'b000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2, id_is_load, id_is_mul;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       PCsrc, jal_mem, jalr_mem, mem_wait;
    logic       flush, hazard_detected, PC_write, IFID_write, IDEX_bubble, IDEX_write;
    logic [5:0] outs;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREGS(NREGS), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .FLUSH_AGE(FLUSH_AGE)
    ) u_dut (
        .CLK(clk), .RST(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_is_mul(id_is_mul),
        .PCsrc(PCsrc), .jal_mem(jal_mem), .jalr_mem(jalr_mem), .mem_wait(mem_wait),
        .flush(flush), .hazard_detected(hazard_detected), .PC_write(PC_write),
        .IFID_write(IFID_write), .IDEX_bubble(IDEX_bubble), .IDEX_write(IDEX_write)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    assign outs = {flush, hazard_detected, PC_write, IFID_write, IDEX_bubble, IDEX_write};

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // ------------------------------------------------------------------------
    // Reference model: timestamps in "active" (non-waiting) cycles
    // ------------------------------------------------------------------------
    int act;
    int ready_at  [NREGS];
    int issued_at [NREGS];
    int exp_stall;
    int exp_flush;

    function automatic bit busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return ready_at[r] > act;
    endfunction

    function automatic logic [5:0] model_out();
        bit redirect, raw;
        redirect = PCsrc || jal_mem || jalr_mem;
        raw = id_valid && ((id_use_rs1 && busy(id_rs1)) || (id_use_rs2 && busy(id_rs2)));
        if (mem_wait) return c_WAIT;
        if (redirect) return c_REDIR;
        if (raw)      return c_STALL;
        return c_RUN;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            act <= 0;
            for (int i = 0; i < NREGS; i++) begin
                ready_at[i]  <= 0;
                issued_at[i] <= -1000;
            end
            exp_stall <= 0;
            exp_flush <= 0;
        end else begin
            exp_stall <= exp_stall + (model_out() == c_STALL ? 1 : 0);
            exp_flush <= exp_flush + (model_out() == c_REDIR ? 1 : 0);
            if (!mem_wait) begin
                if (model_out() == c_REDIR) begin
                    // Squash results of producers issued too recently to survive.
                    for (int i = 1; i < NREGS; i++)
                        if (ready_at[i] > act && (act - issued_at[i] - 1) < FLUSH_AGE)
                            ready_at[i] <= 0;
                end
                if (id_valid && model_out() == c_RUN && id_rd != 5'd0) begin
                    if (id_is_load || id_is_mul) begin
                        issued_at[id_rd] <= act;
                        ready_at[id_rd]  <= act + 1 + (id_is_load ? LOAD_LAT : MUL_LAT);
                    end else begin
                        ready_at[id_rd]  <= 0;
                    end
                end
                act <= act + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (outs !== model_out()) begin
                bad++;
                $display("FAIL model_cmp t=%0t got=%b want=%b", $time, outs, model_out());
            end
`ifdef HAZARD_PERF_EN
            total++;
            if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
                bad++;
                $display("FAIL perf_cnt t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, stall_cnt, flush_cnt, exp_stall, exp_flush);
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------------
    task automatic idle();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_load = 0; id_is_mul = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        PCsrc = 0; jal_mem = 0; jalr_mem = 0; mem_wait = 0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic ld, input logic ml,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        id_valid = 1; id_rd = rd; id_is_load = ld; id_is_mul = ml;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    // Checks the DUT and the model against a hand-derived vector, then
    // advances one cycle.
    task automatic lit(input string nm, input logic [5:0] want);
        @(negedge clk);
        total++;
        if (outs !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, outs, want);
        end
        total++;
        if (model_out() !== want) begin
            bad++;
            $display("FAIL %s_model got=%b want=%b", nm, model_out(), want);
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
`ifdef HAZARD_PERF_EN
        logic [31:0] s0;
`endif
        idle();
        rst = 1;
        @(posedge clk); #1;
        chk_en = 1;

        // Reset: nothing pending, reader of x5 proceeds
        instr(0, 0, 0, 5, 1, 0, 0);
        lit("reset_rd5", c_RUN);
        rst = 0;
        lit("after_rst_rd5", c_RUN);

        // Load-use: exactly one bubble
        instr(5, 1, 0, 0, 0, 0, 0);   lit("load_x5_issue", c_RUN);
        instr(6, 0, 0, 5, 1, 0, 0);   lit("load_use_stall", c_STALL);
        lit("load_use_go", c_RUN);

`ifdef HAZARD_PERF_EN
        s0 = stall_cnt;
`endif
        // Multiply: three stalls, two waits inserted in the middle
        instr(7, 0, 1, 0, 0, 0, 0);   lit("mul_x7_issue", c_RUN);
        instr(8, 0, 0, 0, 0, 7, 1);   lit("mul_stall1", c_STALL);
        mem_wait = 1;                  lit("mul_wait1", c_WAIT);
        lit("mul_wait2", c_WAIT);
        mem_wait = 0;                  lit("mul_stall2", c_STALL);
        lit("mul_stall3", c_STALL);
        lit("mul_go", c_RUN);
`ifdef HAZARD_PERF_EN
        total++;
        if (stall_cnt - s0 !== 32'd3) begin
            bad++;
            $display("FAIL stall_cnt_t3 got=%0d want=3", stall_cnt - s0);
        end
`endif

        // Redirect squashes a just-issued load and a just-issued multiply
        instr(9, 1, 0, 0, 0, 0, 0);   lit("load_x9_issue", c_RUN);
        instr(0, 0, 0, 9, 1, 0, 0); PCsrc = 1; lit("pcsrc_flush", c_REDIR);
        PCsrc = 0;                     lit("x9_after_flush", c_RUN);
        instr(10, 0, 1, 0, 0, 0, 0);  lit("mul_x10_issue", c_RUN);
        instr(0, 0, 0, 10, 1, 0, 0); jal_mem = 1; lit("jal_flush", c_REDIR);
        jal_mem = 0;                   lit("x10_after_flush", c_RUN);
        idle(); jalr_mem = 1;          lit("jalr_flush", c_REDIR);

        // Redirect deferred by mem_wait
        idle(); PCsrc = 1; mem_wait = 1; lit("redir_under_wait", c_WAIT);
        mem_wait = 0;                  lit("redir_after_wait", c_REDIR);
        idle();

        // x0 never tracked; rs1==rs2 on a busy register
        instr(0, 1, 0, 0, 0, 0, 0);   lit("load_x0_issue", c_RUN);
        instr(3, 0, 0, 0, 1, 0, 1);   lit("x0_reader", c_RUN);
        instr(11, 0, 1, 0, 0, 0, 0);  lit("mul_x11_issue", c_RUN);
        instr(4, 0, 0, 11, 1, 11, 1); lit("same_src_stall1", c_STALL);
        lit("same_src_stall2", c_STALL);
        lit("same_src_stall3", c_STALL);
        lit("same_src_go", c_RUN);

        // Untracked writer drops an older pending result
        instr(12, 0, 1, 0, 0, 0, 0);  lit("mul_x12_issue", c_RUN);
        instr(12, 0, 0, 0, 0, 0, 0);  lit("alu_x12_issue", c_RUN);
        instr(13, 0, 0, 12, 1, 0, 0); lit("x12_reader", c_RUN);
        idle();

        // Randomised phase, checked every cycle by the model
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 499) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 7));
            id_use_rs1 = ($urandom_range(0, 3) != 0);
            id_use_rs2 = ($urandom_range(0, 1) != 0);
            id_is_load = ($urandom_range(0, 3) == 0);
            id_is_mul  = ($urandom_range(0, 3) == 0);
            PCsrc      = ($urandom_range(0, 15) == 0);
            jal_mem    = ($urandom_range(0, 31) == 0);
            jalr_mem   = ($urandom_range(0, 31) == 0);
            mem_wait   = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end

        idle();
        rst = 0;
        @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
